seg_dyn_scan_ctrl: RTL and testbench

Scan controller for the 6-digit multiplexed seven-segment display. It takes the binary value, decimal-point mask, sign and enable from the display data source. It converts the value to BCD with a sequential double-dabble engine, then applies leading-zero blanking and sign placement. It time-multiplexes the six digits onto the shared segment bus, driving active-low digit select and active-low segment lines (common-anode board).

---
 rtl/seg_pkg.sv | 53 +++++
 rtl/seg_dyn_scan_ctrl_if.sv | 16 +
 rtl/seg_dyn_scan_ctrl_bin2bcd.sv | 66 ++++++
 rtl/seg_dyn_scan_ctrl.sv | 86 ++++++++
 tb/tb_seg_dyn_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, glyph table and BCD helpers for the scan controller
package seg_pkg;

    localparam int DIGITS = 6;
    localparam int DP_BIT = 7;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        BCD_IDLE   = 2'd0,
        BCD_LOAD   = 2'd1,
        BCD_SHIFT  = 2'd2,
        BCD_UPDATE = 2'd3
    } bcd_state_t;

    function automatic logic [7:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction step: any nibble of 5 or more gets +3 before the shift.
    function automatic logic [23:0] bcd_adjust(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_dyn_scan_ctrl_if.sv
// rtl/seg_dyn_scan_ctrl_if.sv - display data source and panel drive signals of the scan controller
interface seg_dyn_scan_ctrl_if;
    import seg_pkg::*;

    logic [19:0]       data;
    logic [DIGITS-1:0] point;
    logic              sign;
    logic              seg_en;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;
    logic              busy;

    modport master (output data, point, sign, seg_en, input sel, seg, busy);
    modport slave  (input data, point, sign, seg_en, output sel, seg, busy);

endinterface

// File: rtl/seg_dyn_scan_ctrl_bin2bcd.sv
// rtl/seg_dyn_scan_ctrl_bin2bcd.sv - sequential 20-bit to 6-digit BCD double-dabble engine
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [19:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bin_q,
    output logic [23:0] bcd
);

    bcd_state_t  state, state_nxt;
    logic [43:0] sr;
    logic [43:0] sr_adj;
    logic [4:0]  shift_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= BCD_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BCD_IDLE:   if (start) state_nxt = BCD_LOAD;
            BCD_LOAD:   state_nxt = BCD_SHIFT;
            BCD_SHIFT:  if (shift_cnt == 5'd19) state_nxt = BCD_UPDATE;
            BCD_UPDATE: state_nxt = BCD_IDLE;
            default:    state_nxt = BCD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != BCD_IDLE);
        done = (state == BCD_UPDATE);
    end

    assign sr_adj = {bcd_adjust(sr[43:20]), sr[19:0]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr        <= '0;
            shift_cnt <= '0;
            bin_q     <= '0;
            bcd       <= '0;
        end else begin
            case (state)
                BCD_LOAD: begin
                    sr        <= {24'd0, bin};
                    bin_q     <= bin;
                    shift_cnt <= '0;
                end
                BCD_SHIFT: begin
                    sr        <= {sr_adj[42:0], 1'b0};
                    shift_cnt <= shift_cnt + 5'd1;
                end
                BCD_UPDATE: bcd <= sr[43:20];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_dyn_scan_ctrl.sv
// rtl/seg_dyn_scan_ctrl.sv - 6-digit multiplexed seven-segment scan controller (common anode)
module seg_dyn_scan_ctrl
    import seg_pkg::*;
#(
    parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999,
    parameter logic [19:0] DATA_CLAMP   = 20'd999_999
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    seg_dyn_scan_ctrl_if.slave bus
);

    logic [15:0] cnt;
    logic [2:0]  idx;
    logic        tick;
    logic        first_q;
    logic [19:0] clamped;
    logic [19:0] bin_q;
    logic [23:0] bcd;
    logic        conv_busy;
    logic        conv_done;
    logic        start;
    logic [2:0]  lim;
    logic [3:0]  digit;
    logic [7:0]  glyph;

    assign clamped = (bus.data > DATA_CLAMP) ? DATA_CLAMP : bus.data;
    // Requests are only honoured in IDLE; first_q forces one conversion after reset.
    assign start   = first_q | (!conv_busy && !conv_done && (clamped != bin_q));
    assign tick    = (cnt == CNT_SCAN_MAX);

    bin2bcd_seq u_bin2bcd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .bin       (clamped),
        .busy      (conv_busy),
        .done      (conv_done),
        .bin_q     (bin_q),
        .bcd       (bcd)
    );

    assign bus.busy = conv_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            first_q <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
        end else begin
            first_q <= 1'b0;
            cnt     <= tick ? 16'd0 : cnt + 16'd1;
            if (tick) idx <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end
    end

    always_comb begin
        lim = 3'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if ((bcd[4*i +: 4] != 4'd0) || bus.point[i]) lim = 3'(i);
        end
        digit = bcd[{idx, 2'b00} +: 4];
        if (idx <= lim)
            glyph = seg_glyph(digit);
        else if (bus.sign && (lim != 3'(DIGITS - 1)) && (idx == lim + 3'd1))
            glyph = SEG_MINUS;
        else
            glyph = SEG_BLANK;
        if (bus.point[idx]) glyph[DP_BIT] = 1'b0;
    end

    // sel and seg share one register stage so they always describe the same digit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.sel <= 6'h3F;
            bus.seg <= SEG_BLANK;
        end else if (!bus.seg_en) begin
            bus.sel <= 6'h3F;
            bus.seg <= SEG_BLANK;
        end else begin
            bus.sel <= ~(6'b000001 << idx);
            bus.seg <= glyph;
        end
    end

endmodule

// File: tb/tb_seg_dyn_scan_ctrl.sv
// tb/tb_seg_dyn_scan_ctrl.sv - self-checking bench for seg_dyn_scan_ctrl with a decimal reference model
module tb_seg_dyn_scan_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         cyc       = 0;
    int         disp_v    = 0;
    int         latched_v = 0;
    logic [5:0] cur_pt    = 6'd0;
    bit         cur_sg    = 1'b0;
    logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    seg_dyn_scan_ctrl_if bus ();

    seg_dyn_scan_ctrl #(
        .CNT_SCAN_MAX (16'd9),
        .DATA_CLAMP   (20'd999_999)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    function automatic logic [7:0] exp_seg(input int v, input logic [5:0] pt, input bit sg, input int i);
        int t, msd, lim, p;
        logic [7:0] s;
        t = v; msd = 0;
        while (t >= 10) begin t = t / 10; msd++; end
        lim = msd;
        for (int k = 0; k < 6; k++) if (pt[k] && k > lim) lim = k;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (i <= lim)                        s = glyph_tab[(v / p) % 10];
        else if (sg && lim < 5 && i == lim + 1) s = 8'hBF;
        else                                 s = 8'hFF;
        if (pt[i]) s = s & 8'h7F;
        return s;
    endfunction

    task automatic check_frame(input string name, input int n);
        int e;
        logic [5:0] es;
        logic [7:0] eg;
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            e  = ((cyc - 1) / 10) % 6;
            es = ~(6'b000001 << e);
            eg = exp_seg(disp_v, cur_pt, cur_sg, e);
            total_cnt++;
            if (bus.sel !== es) $display("FAIL %s sel: got %h expected %h (cycle %0d)", name, bus.sel, es, cyc);
            else pass_cnt++;
            total_cnt++;
            if (bus.seg !== eg) $display("FAIL %s seg digit %0d: got %h expected %h (value %0d)", name, e, bus.seg, eg, disp_v);
            else pass_cnt++;
        end
    endtask

    task automatic wait_conv(input string name, output int hi);
        int t;
        hi = 0; t = 0;
        do begin @(negedge sys_clk); t++; end while (bus.busy !== 1'b1 && t < 6);
        if (bus.busy === 1'b1) begin
            hi = 1;
            while (bus.busy === 1'b1 && hi < 60) begin
                @(negedge sys_clk);
                if (bus.busy === 1'b1) hi++;
            end
        end
        total_cnt++;
        if (hi == 0 || bus.busy !== 1'b0)
            $display("FAIL %s conversion: busy high %0d cycles, busy now %b, expected a finished conversion", name, hi, bus.busy);
        else pass_cnt++;
        @(negedge sys_clk);
    endtask

    task automatic apply(input string name, input int d, input logic [5:0] pt, input bit sg, output int hi);
        int cl;
        cl = (d > 999_999) ? 999_999 : d;
        bus.data  = 20'(d);
        bus.point = pt;
        bus.sign  = sg;
        cur_pt    = pt;
        cur_sg    = sg;
        hi        = 0;
        if (cl != latched_v) begin
            wait_conv(name, hi);
            latched_v = cl;
            disp_v    = cl;
        end else begin
            repeat (2) @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        bus.data = 20'd0; bus.point = 6'd0; bus.sign = 1'b0; bus.seg_en = 1'b1;
        #1 sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        total_cnt++; if (bus.sel !== 6'h3F) $display("FAIL reset sel: got %h expected 3f", bus.sel); else pass_cnt++;
        total_cnt++; if (bus.seg !== 8'hFF) $display("FAIL reset seg: got %h expected ff", bus.seg); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_scan();
        sys_rst_n = 1'b1;
        latched_v = 0; disp_v = 0;
        check_frame("scan_walk", 130);
    endtask

    task automatic test_bcd();
        int hi;
        apply("bcd_123456", 123456, 6'd0, 1'b0, hi);
        total_cnt++;
        if (hi != 22) $display("FAIL busy_length: got %0d cycles expected 22", hi); else pass_cnt++;
        check_frame("bcd_123456", 60);
    endtask

    task automatic test_sign_blank();
        int hi;
        apply("sign_42", 42, 6'd0, 1'b1, hi);
        check_frame("sign_42", 60);
        apply("sign_654321", 654321, 6'd0, 1'b1, hi);
        check_frame("sign_654321", 60);
    endtask

    task automatic test_point();
        int hi;
        apply("point_5", 5, 6'b000010, 1'b0, hi);
        check_frame("point_5", 60);
    endtask

    task automatic test_clamp_restart();
        int t, n, e;
        logic [7:0] eg;
        cur_pt = 6'd0; cur_sg = 1'b0;
        bus.point = 6'd0; bus.sign = 1'b0;
        bus.data = 20'd1_048_575;
        t = 0;
        do begin @(negedge sys_clk); t++; end while (bus.busy !== 1'b1 && t < 6);
        repeat (5) @(negedge sys_clk);
        bus.data = 20'd7;
        t = 0;
        while (bus.busy === 1'b1 && t < 40) begin @(negedge sys_clk); t++; end
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL clamp_first_done: busy got %b expected 0", bus.busy); else pass_cnt++;
        disp_v = 999_999;
        t = 0;
        while (bus.busy !== 1'b1 && t < 4) begin @(negedge sys_clk); t++; end
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL clamp_restart: busy got %b expected 1", bus.busy); else pass_cnt++;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            e  = ((cyc - 1) / 10) % 6;
            eg = exp_seg(999_999, 6'd0, 1'b0, e);
            total_cnt++;
            if (bus.seg !== eg) $display("FAIL clamp_999999 seg digit %0d: got %h expected %h", e, bus.seg, eg);
            else pass_cnt++;
            n++;
            @(negedge sys_clk);
        end
        @(negedge sys_clk);
        latched_v = 7; disp_v = 7;
        check_frame("clamp_then_7", 60);
    endtask

    task automatic test_seg_en();
        repeat (3) @(negedge sys_clk);
        bus.seg_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            total_cnt++; if (bus.sel !== 6'h3F) $display("FAIL seg_en_off sel: got %h expected 3f", bus.sel); else pass_cnt++;
            total_cnt++; if (bus.seg !== 8'hFF) $display("FAIL seg_en_off seg: got %h expected ff", bus.seg); else pass_cnt++;
        end
        bus.seg_en = 1'b1;
        check_frame("seg_en_back", 30);
    endtask

    task automatic test_async_reset();
        int t, hi;
        bus.data = 20'd888_888;
        t = 0;
        do begin @(negedge sys_clk); t++; end while (bus.busy !== 1'b1 && t < 6);
        repeat (4) @(negedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.sel !== 6'h3F) $display("FAIL async_reset sel: got %h expected 3f", bus.sel); else pass_cnt++;
        total_cnt++; if (bus.seg !== 8'hFF) $display("FAIL async_reset seg: got %h expected ff", bus.seg); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL async_reset busy: got %b expected 0", bus.busy); else pass_cnt++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        latched_v = 0; disp_v = 0;
        wait_conv("reset_restart", hi);
        latched_v = 888_888; disp_v = 888_888;
        check_frame("reset_restart", 60);
    endtask

    task automatic test_random();
        int r, d, m, hi;
        logic [5:0] pt;
        bit sg;
        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(1, 7);
            if (r == 7) d = $urandom_range(999_999, 1_048_575);
            else begin
                m = 1;
                for (int k = 0; k < r; k++) m = m * 10;
                d = $urandom_range(0, m - 1);
            end
            pt = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            sg = 1'($urandom_range(0, 1));
            apply("random", d, pt, sg, hi);
            check_frame("random", 60);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_bcd();
        test_sign_blank();
        test_point();
        test_clamp_restart();
        test_seg_en();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
